imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-time sequencer for the single-ported, word-addressed instruction RAM.
- Receives a length-prefixed little-endian byte stream, for example from a UART receiver.
- Packs the bytes into 32-bit words and writes them to consecutive RAM words starting at word 0.
- Holds the core stalled until the image is complete, then hands the RAM address port to instruction fetch.

Parameters:
- DEPTH, 64, instruction RAM size in 32-bit words.
- ADDR_W, 6, word-address width; must equal clog2(DEPTH).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- byte_valid  in  1  stream byte present
- byte_data  in  8  stream byte
- byte_ready  out  1  loader accepts a byte; a transfer occurs when byte_valid && byte_ready on a rising clk edge
- restart  in  1  single-cycle pulse; starts a new load from DONE or ERR
- pc  in  32  fetch byte address from the core
- mem_addr  out  ADDR_W  RAM word address
- mem_we  out  1  RAM write enable
- mem_wd  out  32  RAM write data
- cpu_stall  out  1  core must hold its PC and fetch nothing
- load_done  out  1  image loaded successfully
- load_err  out  1  header length was invalid

Behaviour:
- Reset clocking and polarity: one clock, clk. Reset is asynchronous and active-low, on reset_n.
- Values while reset_n is low:
  - state = LEN_LO, cpu_stall = 1.
  - mem_we = 0, mem_wd = 0.
  - load_done = 0, load_err = 0.
  - Byte index = 0, word counter = 0, length register = 0.
- Reset mid-load: everything returns to the values above. RAM contents already written are not cleared.
- Stream format:
  - Byte 0 = LEN[7:0], byte 1 = LEN[15:8].
  - Then LEN words, 4 bytes each, least-significant byte first: byte k of a word goes to bits [8k+7:8k].
- States:
  - LEN_LO: byte_ready = 1. On transfer, latch the low length byte and go to LEN_HI.
  - LEN_HI: byte_ready = 1. On transfer, form LEN.
    - If LEN == 0 or LEN > DEPTH, go to ERR.
    - Otherwise go to DATA.
  - DATA: byte_ready = 1. Each transfer shifts a byte into the assembler.
    - On the 4th byte of a word: in the next cycle mem_we = 1 for exactly one cycle, mem_wd = assembled word, mem_addr = word counter. The word counter then increments.
    - The write cycle of the final word (word counter == LEN-1) moves to DONE.
    - There is no backpressure: the next word's bytes may be accepted during the write cycle.
  - DONE: byte_ready = 0, load_done = 1.
    - cpu_stall falls in the cycle after the final mem_we pulse.
  - ERR: byte_ready = 0, load_err = 1, cpu_stall = 1.
- restart:
  - In DONE or ERR: go to LEN_LO next cycle; cpu_stall = 1, load_done = 0, load_err = 0, counters cleared.
  - In any other state: ignored.
  - restart together with byte_valid: restart wins and the byte is not accepted.
- Address mux (combinational):
  - mem_addr = pc[ADDR_W+1:2] when cpu_stall == 0.
  - Otherwise mem_addr = word counter, held at 0 in LEN_LO/LEN_HI/ERR.
  - pc[1:0] and pc[31:ADDR_W+2] are ignored.
- Width rules:
  - The word counter is ADDR_W+1 bits so that LEN == DEPTH is representable.
  - LEN is compared at 16 bits.
  - The word counter never wraps, because LEN ≤ DEPTH.
- mem_we is never asserted outside DATA and the final write cycle.

Decomposition:
- Package imem_loader_pkg holds:
  - the state enum (LEN_LO, LEN_HI, DATA, DONE, ERR),
  - LEN_W = 16,
  - BYTES_PER_WORD = 4.
- One sub-module, byte_word_packer:
  - 2-bit byte index and 32-bit shift register.
  - Flags word_full on the 4th accepted byte; clear input resets the index.
- The FSM, counters, write register and address mux live in imem_loader.

Test Plan:
- Nominal load:
  - Stimulus: stream 02 00, 13 05 50 00, 93 05 60 00 with byte_valid held high.
  - Required: mem_we pulses twice, at addr 0 with data 0x00500513 and at addr 1 with data 0x00600593; cpu_stall falls the cycle after the 2nd pulse; load_done = 1; mem_addr then tracks pc = 0x4 → 1.
- Zero length:
  - Stimulus: stream 00 00.
  - Required: ERR; load_err = 1; byte_ready = 0; cpu_stall stays 1; no mem_we.
- Oversize length:
  - Stimulus: LEN = 65 (41 00) with DEPTH = 64.
  - Required: ERR.
  - Stimulus: LEN = 64.
  - Required: 64 writes at addrs 0..63, then DONE.
- Gapped stream:
  - Stimulus: byte_valid toggled randomly for 3 words.
  - Required: identical RAM contents and addresses; each mem_we exactly one cycle.
- Reset mid-load:
  - Stimulus: reset_n asserted low after 6 data bytes.
  - Required: outputs at reset values, state LEN_LO; a subsequent 1-word load writes addr 0.
- Restart:
  - Stimulus: in DONE, restart pulsed while byte_valid = 1.
  - Required: byte not consumed; cpu_stall = 1 next cycle; load_done = 0; a reload succeeds.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-RAM boot loader.
// Stream header is a 16-bit little-endian word count followed by 32-bit words.
package imem_loader_pkg;

   localparam int LEN_W          = 16;
   localparam int BYTES_PER_WORD = 4;

   typedef enum logic [2:0] {
      LEN_LO,
      LEN_HI,
      DATA,
      DONE,
      ERR
   } state_e;

endpackage

// File: rtl/byte_word_packer.sv
// Little-endian byte-to-word assembler.
// word_full_o and word_o are valid together in the cycle the last byte of a word is accepted.
module byte_word_packer
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        clear_i,
   input  logic        byte_en_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic        word_full_o
);

   logic [1:0]  idx_q, idx_d;
   logic [31:0] shreg_q, shreg_d;

   always_comb begin
      idx_d   = idx_q;
      shreg_d = shreg_q;
      if (clear_i) begin
         idx_d = '0;
      end else if (byte_en_i) begin
         idx_d   = idx_q + 2'd1;
         shreg_d = {byte_i, shreg_q[31:8]};
      end
   end

   // Shifting in from the top leaves the first byte at [7:0] after four bytes.
   assign word_full_o = byte_en_i && !clear_i && (idx_q == 2'(BYTES_PER_WORD - 1));
   assign word_o      = {byte_i, shreg_q[31:8]};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idx_q   <= '0;
         shreg_q <= '0;
      end else begin
         idx_q   <= idx_d;
         shreg_q <= shreg_d;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: fills instruction RAM from a length-prefixed byte stream,
// stalling the core until done, then hands the RAM address port to fetch.
//
// state  | meaning
// LEN_LO | waiting for low byte of word count
// LEN_HI | waiting for high byte of word count; validates length
// DATA   | packing bytes into words and writing them to RAM
// DONE   | image loaded, core running from RAM
// ERR    | invalid length received, core held stalled
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   input  logic              restart,
   input  logic [31:0]       pc,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [31:0]       mem_wd,
   output logic              cpu_stall,
   output logic              load_done,
   output logic              load_err
);

   localparam logic [ADDR_W:0] WCNT_ONE = 1;

   state_e             state_q, state_d;
   logic [LEN_W-1:0]   len_q, len_d, len_hdr;
   logic [ADDR_W:0]    wcnt_q, wcnt_d;
   logic               we_q, we_d;
   logic [31:0]        wd_q, wd_d;
   logic               xfer, word_full, last_word;
   logic [31:0]        word;

   assign byte_ready = (state_q == LEN_LO) || (state_q == LEN_HI) || (state_q == DATA);
   assign xfer       = byte_valid && byte_ready;
   assign len_hdr    = {byte_data, len_q[7:0]};
   assign last_word  = (LEN_W'(wcnt_q) == (len_q - LEN_W'(1)));

   byte_word_packer u_packer (
      .clk         (clk),
      .reset_n     (reset_n),
      .clear_i     (state_q != DATA),
      .byte_en_i   (xfer && (state_q == DATA)),
      .byte_i      (byte_data),
      .word_o      (word),
      .word_full_o (word_full)
   );

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      wcnt_d  = wcnt_q;
      we_d    = 1'b0;
      wd_d    = wd_q;
      if (word_full) begin
         we_d = 1'b1;
         wd_d = word;
      end
      case (state_q)
         LEN_LO: if (xfer) begin
            len_d   = LEN_W'(byte_data);
            state_d = LEN_HI;
         end
         LEN_HI: if (xfer) begin
            len_d = len_hdr;
            if ((len_hdr == '0) || (len_hdr > LEN_W'(DEPTH))) state_d = ERR;
            else                                             state_d = DATA;
         end
         // The counter advances on the write cycle, so it addresses the word being written.
         DATA: if (we_q) begin
            wcnt_d = wcnt_q + WCNT_ONE;
            if (last_word) state_d = DONE;
         end
         DONE, ERR: if (restart) begin
            state_d = LEN_LO;
            len_d   = '0;
            wcnt_d  = '0;
         end
         default: state_d = LEN_LO;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= LEN_LO;
         len_q   <= '0;
         wcnt_q  <= '0;
         we_q    <= 1'b0;
         wd_q    <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         wcnt_q  <= wcnt_d;
         we_q    <= we_d;
         wd_q    <= wd_d;
      end
   end

   assign mem_we    = we_q;
   assign mem_wd    = wd_q;
   assign cpu_stall = (state_q != DONE);
   assign load_done = (state_q == DONE);
   assign load_err  = (state_q == ERR);

   always_comb begin
      if (!cpu_stall)             mem_addr = pc[ADDR_W+1:2];
      else if (state_q == DATA)   mem_addr = wcnt_q[ADDR_W-1:0];
      else                        mem_addr = '0;
   end

   wire unused_pc = ^{pc[31:ADDR_W+2], pc[1:0]};

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader: expected RAM writes are queued
// from the stream model and popped by an independent write monitor.
module tb_imem_loader;

   typedef logic [31:0] wq_t[$];
   typedef struct {
      int          addr;
      logic [31:0] data;
   } wr_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data = 8'h00;
   logic        restart = 1'b0;
   logic [31:0] pc = 32'h0;
   logic        byte_ready;
   logic [5:0]  mem_addr;
   logic        mem_we;
   logic [31:0] mem_wd;
   logic        cpu_stall;
   logic        load_done;
   logic        load_err;

   int  vectors = 0;
   int  miscompares = 0;
   int  writes_seen = 0;
   wr_t exp_q[$];

   imem_loader #(.DEPTH(64), .ADDR_W(6)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .restart    (restart),
      .pc         (pc),
      .mem_addr   (mem_addr),
      .mem_we     (mem_we),
      .mem_wd     (mem_wd),
      .cpu_stall  (cpu_stall),
      .load_done  (load_done),
      .load_err   (load_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Write monitor: every write must match the head of the expected queue.
   logic prev_we = 1'b0;
   logic prev_stall = 1'b1;
   always @(negedge clk) begin
      wr_t e;
      if (mem_we === 1'b1) begin
         writes_seen++;
         check("we_single_cycle", 32'(prev_we), 32'd0);
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_write: got write addr %0d data 0x%08h, expected none", mem_addr, mem_wd);
         end else begin
            e = exp_q.pop_front();
            check("wr_addr", 32'(mem_addr), e.addr);
            check("wr_data", mem_wd, e.data);
         end
      end
      if (prev_stall === 1'b1 && cpu_stall === 1'b0) begin
         check("stall_fall_after_we", 32'(prev_we), 32'd1);
         check("queue_drained_at_run", exp_q.size(), 0);
      end
      prev_we    = mem_we;
      prev_stall = cpu_stall;
   end

   function automatic wq_t rand_words(input int n);
      wq_t q;
      for (int i = 0; i < n; i++) q.push_back($urandom);
      return q;
   endfunction

   // Called and returns at 1 time unit after a rising edge.
   task automatic send_byte(input logic [7:0] b, input bit gapped);
      logic rdy;
      int   t;
      if (gapped) begin
         repeat ($urandom_range(0, 3)) begin
            byte_valid = 1'b0;
            @(posedge clk); #1;
         end
      end
      byte_valid = 1'b1;
      byte_data  = b;
      for (t = 0; t < 50; t++) begin
         @(negedge clk);
         rdy = byte_ready;
         @(posedge clk); #1;
         if (rdy) break;
      end
      if (t == 50) begin
         vectors++;
         miscompares++;
         $display("FAIL byte_accept_timeout: got no byte_ready in 50 cycles, expected acceptance");
      end
   endtask

   task automatic wait_outcome(input bit exp_done);
      int t;
      for (t = 0; t < 100; t++) begin
         @(negedge clk);
         if (load_done || load_err) break;
      end
      if (t == 100) begin
         vectors++;
         miscompares++;
         $display("FAIL outcome_timeout: got no done/err in 100 cycles, expected one");
      end
      check("load_done", 32'(load_done), 32'(exp_done));
      check("load_err", 32'(load_err), 32'(!exp_done));
      check("ready_after_load", 32'(byte_ready), 32'd0);
      check("stall_after_load", 32'(cpu_stall), 32'(!exp_done));
      @(posedge clk); #1;
   endtask

   task automatic do_load(input int len, input wq_t words, input bit gapped);
      bit ok;
      int w0;
      ok = (len >= 1) && (len <= 64);
      w0 = writes_seen;
      send_byte(len[7:0], gapped);
      send_byte(len[15:8], gapped);
      if (ok) begin
         for (int i = 0; i < len; i++) begin
            exp_q.push_back('{i, words[i]});
            for (int k = 0; k < 4; k++) send_byte(8'((words[i] >> (8 * k)) & 32'hFF), gapped);
         end
      end
      byte_valid = 1'b0;
      wait_outcome(ok);
      check("write_count", writes_seen - w0, ok ? len : 0);
      check("queue_empty", exp_q.size(), 0);
   endtask

   task automatic pulse_restart();
      restart    = 1'b1;
      byte_valid = 1'b1;
      byte_data  = 8'hA5;
      @(negedge clk);
      check("ready_during_restart", 32'(byte_ready), 32'd0);
      @(posedge clk); #1;
      restart    = 1'b0;
      byte_valid = 1'b0;
      @(negedge clk);
      check("restart_stall", 32'(cpu_stall), 32'd1);
      check("restart_done", 32'(load_done), 32'd0);
      check("restart_err", 32'(load_err), 32'd0);
      check("restart_ready", 32'(byte_ready), 32'd1);
      check("restart_addr", 32'(mem_addr), 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_stall"}, 32'(cpu_stall), 32'd1);
      check({tag, "_we"}, 32'(mem_we), 32'd0);
      check({tag, "_wd"}, mem_wd, 32'd0);
      check({tag, "_done"}, 32'(load_done), 32'd0);
      check({tag, "_err"}, 32'(load_err), 32'd0);
      check({tag, "_ready"}, 32'(byte_ready), 32'd1);
      check({tag, "_addr"}, 32'(mem_addr), 32'd0);
   endtask

   initial begin
      wq_t w;
      int  len;

      repeat (3) @(posedge clk);
      #1;
      check_reset_values("reset");
      reset_n = 1'b1;
      @(posedge clk); #1;

      // Nominal two-word image, then fetch addressing.
      w = '{32'h00500513, 32'h00600593};
      do_load(2, w, 1'b0);
      pc = 32'h4;
      #1 check("pc_addr_4", 32'(mem_addr), 32'd1);
      for (int i = 0; i < 4; i++) begin
         pc = $urandom;
         #1 check("pc_addr_rand", 32'(mem_addr), (pc >> 2) & 32'h3F);
      end
      @(posedge clk); #1;

      pulse_restart();
      do_load(1, rand_words(1), 1'b0);

      pulse_restart();
      do_load(0, rand_words(0), 1'b0);
      pc = $urandom;
      #1 check("err_addr", 32'(mem_addr), 32'd0);
      @(posedge clk); #1;

      pulse_restart();
      do_load(65, rand_words(0), 1'b0);

      pulse_restart();
      do_load(64, rand_words(64), 1'b0);

      pulse_restart();
      do_load(3, rand_words(3), 1'b1);

      // Reset after six data bytes of a three-word load.
      pulse_restart();
      w = rand_words(1);
      send_byte(8'd3, 1'b0);
      send_byte(8'd0, 1'b0);
      exp_q.push_back('{0, w[0]});
      for (int k = 0; k < 4; k++) send_byte(8'((w[0] >> (8 * k)) & 32'hFF), 1'b0);
      send_byte(8'($urandom), 1'b0);
      send_byte(8'($urandom), 1'b0);
      byte_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b0;
      #1 check_reset_values("midload_reset");
      check("midload_queue", exp_q.size(), 0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      do_load(1, rand_words(1), 1'b0);

      for (int r = 0; r < 5; r++) begin
         pulse_restart();
         len = (r == 2) ? $urandom_range(65, 600) : $urandom_range(1, 8);
         do_load(len, rand_words((len <= 64) ? len : 0), r[0]);
      end

      check("final_queue", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
